// File: rtl/ov7670_transmitter.sv
// OV7670 sensor emulator: builds PCLK/VSYNC/HREF/byte timing from a 1-cycle-latency frame buffer.
// IDLE: PCLK low, waiting | VSYNC: VS high | VFRONT: blank before rows | ACTIVE: HREF, bytes | HBLANK: line gap | VBACK: frame tail
module ov7670_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int H_WIDTH    = 320,
  parameter int V_WIDTH    = 240,
  parameter int PXL_WIDTH  = 16,
  parameter int PCLK_DIV   = 2,
  parameter int H_BLANK    = 144,
  parameter int VS_LINES   = 3,
  parameter int V_FRONT    = 17,
  parameter int V_BACK     = 10
) (
  input  logic                         i_clk,
  input  logic                         i_n_reset,
  input  logic                         i_start,
  input  logic                         i_stop,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic                         o_pix_rd,
  output logic [$clog2(H_WIDTH):0]     o_h_addr,
  output logic [$clog2(V_WIDTH):0]     o_v_addr,
  input  logic [PXL_WIDTH-1:0]         i_pixel_data,
  output logic                         o_PCLK,
  output logic                         o_VS,
  output logic                         o_HS,
  output logic [DATA_WIDTH-1:0]        o_DATA
);
  localparam int LINE = 2*H_WIDTH + H_BLANK;
  localparam int HW   = $clog2(H_WIDTH) + 1;
  localparam int VW   = $clog2(V_WIDTH) + 1;
  localparam int PW   = $clog2(LINE + 1);
  localparam int LW   = $clog2(VS_LINES + V_FRONT + V_BACK + 1);
  localparam int DCW  = $clog2(PCLK_DIV);

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    VSYNC  = 6'b000010,
    VFRONT = 6'b000100,
    ACTIVE = 6'b001000,
    HBLANK = 6'b010000,
    VBACK  = 6'b100000
  } state_t;

  state_t                  state;
  logic [DCW-1:0]          div_cnt;
  logic [PW-1:0]           pcnt;
  logic [LW-1:0]           lcnt;
  logic [VW-1:0]           row;
  logic                    stop_pend;
  logic                    rd_d;
  logic [PXL_WIDTH-1:0]    pix_q;
  logic                    wrap, fall, rise, line_end;
  logic [2*DATA_WIDTH-1:0] p_ext;

  // state/pcnt always describe the period the next fall tick will launch
  assign wrap     = (state != IDLE) && (div_cnt == DCW'(PCLK_DIV - 1));
  assign fall     = wrap && o_PCLK;
  assign rise     = wrap && !o_PCLK;
  assign line_end = (pcnt == PW'(LINE - 1));
  // with PCLK_DIV=2 the read data lands on the very launch cycle, so bypass the register
  assign p_ext    = (2*DATA_WIDTH)'(rd_d ? i_pixel_data : pix_q);

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      pcnt         <= '0;
      lcnt         <= '0;
      row          <= '0;
      stop_pend    <= 1'b0;
      rd_d         <= 1'b0;
      pix_q        <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_pix_rd     <= 1'b0;
      o_h_addr     <= '0;
      o_v_addr     <= '0;
      o_PCLK       <= 1'b0;
      o_VS         <= 1'b0;
      o_HS         <= 1'b0;
      o_DATA       <= '0;
    end else begin
      o_frame_done <= 1'b0;
      o_pix_rd     <= 1'b0;
      rd_d         <= o_pix_rd;
      if (rd_d) pix_q <= i_pixel_data;
      if (i_stop && state != IDLE) stop_pend <= 1'b1;

      if (state == IDLE) begin
        o_PCLK  <= 1'b0;
        div_cnt <= '0;
        if (i_start) begin
          state     <= VSYNC;
          o_busy    <= 1'b1;
          o_PCLK    <= 1'b1;
          pcnt      <= '0;
          lcnt      <= '0;
          row       <= '0;
          stop_pend <= i_stop;
        end
      end else begin
        div_cnt <= wrap ? '0 : div_cnt + 1'b1;
        if (wrap) o_PCLK <= !o_PCLK;

        if (rise && state == ACTIVE && !pcnt[0]) begin
          o_pix_rd <= 1'b1;
          o_h_addr <= HW'(pcnt >> 1);
          o_v_addr <= row;
        end

        if (fall) begin
          o_VS   <= (state == VSYNC);
          o_HS   <= (state == ACTIVE);
          o_DATA <= '0;
          pcnt   <= pcnt + 1'b1;
          case (state)
            VSYNC: if (line_end) begin
              pcnt <= '0;
              if (lcnt == LW'(VS_LINES - 1)) begin
                lcnt  <= '0;
                state <= VFRONT;
              end else lcnt <= lcnt + 1'b1;
            end
            VFRONT: if (line_end) begin
              pcnt <= '0;
              if (lcnt == LW'(V_FRONT - 1)) begin
                lcnt  <= '0;
                state <= ACTIVE;
              end else lcnt <= lcnt + 1'b1;
            end
            ACTIVE: begin
              o_DATA <= pcnt[0] ? p_ext[DATA_WIDTH-1:0] : p_ext[2*DATA_WIDTH-1:DATA_WIDTH];
              if (pcnt == PW'(2*H_WIDTH - 1)) begin
                pcnt  <= '0;
                state <= HBLANK;
              end
            end
            HBLANK: if (pcnt == PW'(H_BLANK - 1)) begin
              pcnt <= '0;
              if (row == VW'(V_WIDTH - 1)) state <= VBACK;
              else begin
                row   <= row + 1'b1;
                state <= ACTIVE;
              end
            end
            VBACK: if (line_end) begin
              pcnt <= '0;
              if (lcnt == LW'(V_BACK - 1)) begin
                lcnt         <= '0;
                row          <= '0;
                o_frame_done <= 1'b1;
                if (stop_pend || i_stop) begin
                  state     <= IDLE;
                  o_busy    <= 1'b0;
                  stop_pend <= 1'b0;
                end else state <= VSYNC;
              end else lcnt <= lcnt + 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule
